// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types for the hazard/stall controller.
// Provides the per-latch control encoding, the register index type,
// the four-latch control bundle and small helper functions.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    typedef logic [REG_W-1:0] regbits_t;

    // Per-pipeline-latch command: advance, hold contents, or load a bubble
    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    // Control for the four pipeline latches, fetch side first
    typedef struct packed {
        pipe_state_t fd;
        pipe_state_t de;
        pipe_state_t em;
        pipe_state_t mw;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t pipe_ctrl(input pipe_state_t fd, input pipe_state_t de,
                                             input pipe_state_t em, input pipe_state_t mw);
        pipe_ctrl_t c;
        c.fd = fd;
        c.de = de;
        c.em = em;
        c.mw = mw;
        return c;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_control_if.sv
// Interface bundling the hazard controller's pipeline-facing signals.
// slave  : the controller (takes hit/hazard inputs, drives latch control and counters)
// master : the pipeline side (drives hit/hazard inputs, observes control)
interface pipeline_hazard_control_if;
    import cpu_types_pkg::*;

    logic                ihit;
    logic                dhit;
    logic                m_dREN;
    logic                m_dWEN;
    logic                e_MemRead;
    regbits_t            e_regWSEL;
    regbits_t            d_rs;
    regbits_t            d_rt;
    logic                d_use_rs;
    logic                d_use_rt;
    logic                e_flush;
    logic                w_halt;

    pipe_state_t         fd_state;
    pipe_state_t         de_state;
    pipe_state_t         em_state;
    pipe_state_t         mw_state;
    logic                pc_en;
    logic                halt;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output ihit, dhit, m_dREN, m_dWEN, e_MemRead, e_regWSEL, d_rs, d_rt,
               d_use_rs, d_use_rt, e_flush, w_halt,
        input  fd_state, de_state, em_state, mw_state, pc_en, halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, m_dREN, m_dWEN, e_MemRead, e_regWSEL, d_rs, d_rt,
               d_use_rs, d_use_rt, e_flush, w_halt,
        output fd_state, de_state, em_state, mw_state, pc_en, halt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in DECODE.
// Ports: e_MemRead_i/e_regWSEL_i (EX load and destination), d_rs_i/d_rt_i with
// d_use_rs_i/d_use_rt_i (DECODE sources actually read), load_use_o (hazard present).
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     e_MemRead_i,
    input  regbits_t e_regWSEL_i,
    input  regbits_t d_rs_i,
    input  regbits_t d_rt_i,
    input  logic     d_use_rs_i,
    input  logic     d_use_rt_i,
    output logic     load_use_o
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency
    assign load_use_o = e_MemRead_i && (e_regWSEL_i != '0) &&
                        ((d_use_rs_i && (d_rs_i == e_regWSEL_i)) ||
                         (d_use_rt_i && (d_rt_i == e_regWSEL_i)));

endmodule

// File: rtl/pipeline_hazard_control.sv
// Pipeline hazard controller: chooses per-latch enable/stall/bubble commands and
// the PC enable from data-memory waits, load-use hazards, EX-resolved flushes,
// instruction-fetch misses and halt; counts stall and flush cycles.
// Ports: CLK, nRST (synchronous active-low), hif (slave side of the pipeline interface).
// Latch control, pc_en and halt are combinational from state and inputs; counters are registered.
module pipeline_hazard_control
    import cpu_types_pkg::*;
(
    input  logic                      CLK,
    input  logic                      nRST,
    pipeline_hazard_control_if.slave  hif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    pipe_ctrl_t       ctrl_c;
    logic             pc_en_c;
    logic             halt_c;
    logic             flush_sel_c;
    logic             load_use_c;
    logic             mem_pending_c;

    hazard_detect u_hazard_detect (
        .e_MemRead_i (hif.e_MemRead),
        .e_regWSEL_i (hif.e_regWSEL),
        .d_rs_i      (hif.d_rs),
        .d_rt_i      (hif.d_rt),
        .d_use_rs_i  (hif.d_use_rs),
        .d_use_rt_i  (hif.d_use_rt),
        .load_use_o  (load_use_c)
    );

    assign mem_pending_c = (hif.m_dREN || hif.m_dWEN) && !hif.dhit;

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Next state and latch control; flush outranks load-use because EX advances and
    // a deferred flush would be lost
    always_comb begin
        state_d     = state_q;
        ctrl_c      = pipe_ctrl(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
        pc_en_c     = 1'b1;
        halt_c      = 1'b0;
        flush_sel_c = 1'b0;

        if (!nRST) begin
            ctrl_c  = pipe_ctrl(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL);
            pc_en_c = 1'b0;
            state_d = RUN;
        end else if (state_q == HALTED) begin
            ctrl_c  = pipe_ctrl(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL);
            pc_en_c = 1'b0;
            halt_c  = 1'b1;
        end else begin
            if (mem_pending_c) begin
                // Hold everything up to MEM; bubble into WB while dmem is busy
                ctrl_c  = pipe_ctrl(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP);
                pc_en_c = 1'b0;
            end else if (hif.e_flush) begin
                // PC loads the branch target even on an imem miss
                ctrl_c      = pipe_ctrl(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
                flush_sel_c = 1'b1;
            end else if (load_use_c) begin
                ctrl_c  = pipe_ctrl(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
                pc_en_c = 1'b0;
            end else if (!hif.ihit) begin
                ctrl_c  = pipe_ctrl(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
                pc_en_c = 1'b0;
            end

            if (hif.w_halt) begin
                state_d = HALTED;
            end else if (mem_pending_c) begin
                state_d = DWAIT;
            end else begin
                state_d = RUN;
            end
        end
    end

    // Saturating event counters; frozen once halted
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en_c && (state_q != HALTED)) begin
            stall_d = sat_inc(stall_q);
        end
        if (flush_sel_c) begin
            flush_d = sat_inc(flush_q);
        end
    end

    assign hif.fd_state  = ctrl_c.fd;
    assign hif.de_state  = ctrl_c.de;
    assign hif.em_state  = ctrl_c.em;
    assign hif.mw_state  = ctrl_c.mw;
    assign hif.pc_en     = pc_en_c;
    assign hif.halt      = halt_c;
    assign hif.stall_cnt = stall_q;
    assign hif.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Self-checking bench for pipeline_hazard_control: a vector table plus hand-written
// sequences for dmem wait, halt/reset and counter saturation.
module tb_pipeline_hazard_control;
    import cpu_types_pkg::*;

    localparam pipe_state_t EN = PIPE_ENABLE;
    localparam pipe_state_t ST = PIPE_STALL;
    localparam pipe_state_t NP = PIPE_NOP;
    localparam int NV = 14;

    typedef struct {
        logic        nrst, ihit, dhit, dren, dwen, mrd;
        logic [4:0]  wsel, rs, rt;
        logic        urs, urt, flush, whalt;
        pipe_state_t fd, de, em, mw;
        logic        pc_en, halt;
        int          sinc, finc;
    } vec_t;

    logic CLK;
    logic nRST;
    int   n_tests;
    int   n_fail;
    int unsigned exp_s;
    int unsigned exp_f;
    vec_t exp_q[$];
    vec_t tbl[NV];

    pipeline_hazard_control_if hif();

    pipeline_hazard_control dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic nrst, input logic ihit, input logic dhit,
                                input logic dren, input logic dwen, input logic mrd,
                                input logic [4:0] wsel, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic flush, input logic whalt,
                                input pipe_state_t fd, input pipe_state_t de,
                                input pipe_state_t em, input pipe_state_t mw,
                                input logic pc_en, input logic halt, input int sinc, input int finc);
        vec_t v;
        v.nrst = nrst; v.ihit = ihit; v.dhit = dhit; v.dren = dren; v.dwen = dwen; v.mrd = mrd;
        v.wsel = wsel; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.flush = flush; v.whalt = whalt;
        v.fd = fd; v.de = de; v.em = em; v.mw = mw;
        v.pc_en = pc_en; v.halt = halt; v.sinc = sinc; v.finc = finc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare outputs mid-cycle and counters after the edge
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        nRST          = v.nrst;
        hif.ihit      = v.ihit;
        hif.dhit      = v.dhit;
        hif.m_dREN    = v.dren;
        hif.m_dWEN    = v.dwen;
        hif.e_MemRead = v.mrd;
        hif.e_regWSEL = v.wsel;
        hif.d_rs      = v.rs;
        hif.d_rt      = v.rt;
        hif.d_use_rs  = v.urs;
        hif.d_use_rt  = v.urt;
        hif.e_flush   = v.flush;
        hif.w_halt    = v.whalt;
        exp_q.push_back(v);
        @(negedge CLK);
        e = exp_q.pop_front();
        check({tag, ".fd"},    32'(hif.fd_state), 32'(e.fd));
        check({tag, ".de"},    32'(hif.de_state), 32'(e.de));
        check({tag, ".em"},    32'(hif.em_state), 32'(e.em));
        check({tag, ".mw"},    32'(hif.mw_state), 32'(e.mw));
        check({tag, ".pc_en"}, 32'(hif.pc_en),    32'(e.pc_en));
        check({tag, ".halt"},  32'(hif.halt),     32'(e.halt));
        @(posedge CLK);
        #1;
        if (!e.nrst) begin
            exp_s = 0;
            exp_f = 0;
        end else begin
            exp_s = exp_s + e.sinc;
            exp_f = exp_f + e.finc;
            if (exp_s > 32'hFFFF) exp_s = 32'hFFFF;
            if (exp_f > 32'hFFFF) exp_f = 32'hFFFF;
        end
        check({tag, ".stall_cnt"}, 32'(hif.stall_cnt), exp_s);
        check({tag, ".flush_cnt"}, 32'(hif.flush_cnt), exp_f);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_s   = 0;
        exp_f   = 0;

        //          nrst ihit dhit dren dwen mrd wsel rs rt urs urt fl wh  fd de em mw  pc ht s f
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NP, EN, EN, EN, 0, 0, 1, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, ST, NP, EN, EN, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0, ST, NP, EN, EN, 0, 0, 1, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, NP, NP, EN, EN, 1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, NP, NP, EN, EN, 1, 0, 0, 1);
        tbl[8]  = mk(1, 1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 1, 0, NP, NP, EN, EN, 1, 0, 0, 1);
        tbl[9]  = mk(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ST, ST, ST, NP, 0, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 0, ST, ST, ST, NP, 0, 0, 1, 0);
        tbl[11] = mk(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 5'd6, 5'd0, 5'd6, 0, 1, 0, 0, ST, NP, EN, EN, 0, 0, 1, 0);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0);

        // Reset cycle: everything held, PC frozen, not halted, counters cleared
        run_vec("reset", mk(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, ST, ST, ST, ST, 0, 0, 0, 0));

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Dmem miss for three cycles, then the hit cycle runs normally
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("dwait%0d", i),
                    mk(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ST, ST, ST, NP, 0, 0, 1, 0));
        end
        run_vec("dhit", mk(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0));
        run_vec("after_dhit", mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NP, EN, EN, EN, 0, 0, 1, 0));

        // Halt arrives together with a dmem miss: this cycle is a miss, then halted for good
        run_vec("halt_in", mk(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, ST, ST, ST, NP, 0, 0, 1, 0));
        run_vec("halted0", mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, ST, ST, ST, ST, 0, 1, 0, 0));
        run_vec("halted1", mk(1, 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, ST, ST, ST, ST, 0, 1, 0, 0));
        run_vec("halted2", mk(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ST, ST, ST, ST, 0, 1, 0, 0));
        run_vec("halt_rst", mk(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, ST, ST, ST, ST, 0, 0, 0, 0));
        run_vec("post_rst", mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0));

        // Reset in the middle of a dmem wait
        run_vec("dw_mid", mk(1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ST, ST, ST, NP, 0, 0, 1, 0));
        run_vec("dw_rst", mk(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ST, ST, ST, ST, 0, 0, 0, 0));
        run_vec("dw_post", mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, EN, EN, EN, EN, 1, 0, 0, 0));

        // Stall counter saturation: long imem miss
        hif.ihit = 1'b0;
        repeat (65540) @(posedge CLK);
        #1;
        check("sat.stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
        check("sat.flush_cnt", 32'(hif.flush_cnt), 32'h0);
        exp_s = 32'hFFFF;
        run_vec("sat_hold", mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NP, EN, EN, EN, 0, 0, 1, 0));

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
